// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: pipeline MEM stage vs. loader/debug port.
// Pipeline wins by default; a starvation guard and a lockable loader burst keep access fair.
module dmem_arbiter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_rd,
  input  logic          p_wr,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;

  logic p_req;
  logic p_g;
  logic l_g;

  always_comb begin
    p_req = p_rd | p_wr;
    p_g   = 1'b0;
    l_g   = 1'b0;
    if (rst) begin
      unique case (state)
        ST_IDLE: begin
          if (l_req && (wait_cnt == WAIT_TOP)) l_g = 1'b1;
          else if (p_req)                      p_g = 1'b1;
          else if (l_req)                      l_g = 1'b1;
        end
        // A broken burst arbitrates like IDLE for one cycle, minus the forced term.
        ST_LOCKED: begin
          if (l_req && l_lock) l_g = 1'b1;
          else if (p_req)      p_g = 1'b1;
          else if (l_req)      l_g = 1'b1;
        end
        ST_COOLDOWN: p_g = p_req;
        default: begin
          p_g = 1'b0;
          l_g = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    l_gnt   = l_g;
    p_stall = p_req & ~p_g & rst;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (p_g) begin
      m_we    = p_wr;
      m_addr  = p_addr;
      m_wdata = p_wdata;
    end else if (l_g) begin
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
    p_rdata = (p_g && !p_wr) ? m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      lock_cnt     <= '0;
      l_rvalid     <= 1'b0;
      l_rdata      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (p_req && l_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;

      if (l_req && !l_g) begin
        if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end

      l_rvalid <= l_g & ~l_we;
      if (l_g && !l_we) l_rdata <= m_rdata;

      unique case (state)
        ST_IDLE: begin
          if (l_g && l_lock) begin
            state    <= ST_LOCKED;
            lock_cnt <= LW'(1);
          end
        end
        ST_LOCKED: begin
          if (l_req && l_lock) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LOCK_TOP - LW'(1)) state <= ST_COOLDOWN;
          end else begin
            state <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          lock_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 memory preset to mem[i]=i.
// Loader read data is scoreboarded: pushed when the grant is expected, popped at l_rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_rd, p_wr;
  logic [7:0]  p_addr;
  logic [15:0] p_wdata;
  logic [15:0] p_rdata;
  logic        p_stall;
  logic        l_req, l_we, l_lock;
  logic [7:0]  l_addr;
  logic [15:0] l_wdata;
  logic        l_gnt, l_rvalid;
  logic [15:0] l_rdata;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic [15:0] conflict_cnt;

  logic [15:0] mem [256];
  bit          mem_ready = 1'b0;
  logic [15:0] sb [$];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.DW(16), .AW(8), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
      mem_ready <= 1'b1;
    end else if (m_we) begin
      mem[m_addr] <= m_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    tick(); tick();
    // Reset: both requesters active, yet nothing may be granted.
    p_wr = 1'b1; p_addr = 8'd250; p_wdata = 16'd13;
    l_req = 1'b1; l_we = 1'b1; l_addr = 8'd1;
    #2;
    chk("rst_l_gnt",   32'(l_gnt),        32'd0);
    chk("rst_p_stall", 32'(p_stall),      32'd0);
    chk("rst_m_we",    32'(m_we),         32'd0);
    chk("rst_m_addr",  32'(m_addr),       32'd0);
    chk("rst_m_wdata", 32'(m_wdata),      32'd0);
    chk("rst_p_rdata", 32'(p_rdata),      32'd0);
    chk("rst_rvalid",  32'(l_rvalid),     32'd0);
    chk("rst_conf",    32'(conflict_cnt), 32'd0);

    // Pipeline write right after reset release.
    tick();
    rst = 1'b1;
    idle();
    p_wr = 1'b1; p_addr = 8'd250; p_wdata = 16'd13;
    #2;
    chk("pw_m_we",    32'(m_we),    32'd1);
    chk("pw_m_addr",  32'(m_addr),  32'd250);
    chk("pw_m_wdata", 32'(m_wdata), 32'd13);
    chk("pw_p_stall", 32'(p_stall), 32'd0);
    tick(); idle(); #2;
    chk("pw_mem250", 32'(mem[250]), 32'd13);

    // Uncontended loader read.
    l_req = 1'b1; l_addr = 8'd7;
    #2;
    chk("lr_gnt",    32'(l_gnt),  32'd1);
    chk("lr_m_addr", 32'(m_addr), 32'd7);
    chk("lr_m_we",   32'(m_we),   32'd0);
    sb.push_back(16'd7);
    tick(); idle(); #2;
    chk("lr_rvalid1", 32'(l_rvalid), 32'd1);
    pop_chk("lr_rdata", l_rdata);
    tick(); #2;
    chk("lr_rvalid0", 32'(l_rvalid), 32'd0);
    chk("lr_hold",    32'(l_rdata),  32'd7);

    // Starvation guard: loader forced in on the 5th contended cycle.
    for (int c = 0; c < 6; c++) begin
      tick();
      p_rd = 1'b1; p_addr = 8'd20; l_req = 1'b1; l_addr = 8'd3;
      #2;
      if (c < 4) begin
        chk("sv_gnt_deny",  32'(l_gnt),   32'd0);
        chk("sv_stall_no",  32'(p_stall), 32'd0);
        chk("sv_p_rdata",   32'(p_rdata), 32'd20);
      end else if (c == 4) begin
        chk("sv_gnt_force", 32'(l_gnt),   32'd1);
        chk("sv_stall_yes", 32'(p_stall), 32'd1);
        chk("sv_p_rdata0",  32'(p_rdata), 32'd0);
        sb.push_back(16'd3);
      end else begin
        chk("sv_gnt_back",  32'(l_gnt),    32'd0);
        chk("sv_stall_bk",  32'(p_stall),  32'd0);
        chk("sv_rvalid",    32'(l_rvalid), 32'd1);
        pop_chk("sv_rdata", l_rdata);
      end
      chk("sv_conf_run", 32'(conflict_cnt), 32'(c));
    end
    tick(); idle(); #2;
    chk("sv_conf6",    32'(conflict_cnt), 32'd6);
    chk("sv_rvalid0",  32'(l_rvalid),     32'd0);

    // Locked burst of LOCK_MAX loader writes, then one COOLDOWN cycle.
    tick();
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 8'd100; l_wdata = 16'h5000;
    #2;
    chk("lk_gnt0",   32'(l_gnt),   32'd1);
    chk("lk_m_we0",  32'(m_we),    32'd1);
    chk("lk_stall0", 32'(p_stall), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      l_addr = 8'(100 + k); l_wdata = 16'(16'h5000 + k);
      p_rd = 1'b1; p_addr = 8'd20;
      #2;
      if (k <= 7) begin
        chk("lk_gnt",    32'(l_gnt),   32'd1);
        chk("lk_stall",  32'(p_stall), 32'd1);
        chk("lk_m_addr", 32'(m_addr),  32'(100 + k));
      end else begin
        chk("lk_cool_gnt",   32'(l_gnt),   32'd0);
        chk("lk_cool_stall", 32'(p_stall), 32'd0);
        chk("lk_cool_rdata", 32'(p_rdata), 32'd20);
      end
    end
    tick(); idle(); #2;
    chk("lk_mem100", 32'(mem[100]),      32'h5000);
    chk("lk_mem107", 32'(mem[107]),      32'h5007);
    chk("lk_mem108", 32'(mem[108]),      32'd108);
    chk("lk_conf",   32'(conflict_cnt),  32'd15);

    // Burst broken by l_lock=0: IDLE-style arbitration, then COOLDOWN.
    tick();
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 8'd30; l_wdata = 16'h0BAD;
    #2;
    chk("br_gnt0", 32'(l_gnt), 32'd1);
    tick();
    l_lock = 1'b0; l_addr = 8'd31; p_rd = 1'b1; p_addr = 8'd20;
    #2;
    chk("br_gnt1",   32'(l_gnt),   32'd0);
    chk("br_rdata1", 32'(p_rdata), 32'd20);
    tick(); p_rd = 1'b0; #2;
    chk("br_cool", 32'(l_gnt), 32'd0);
    tick(); #2;
    chk("br_idle_gnt", 32'(l_gnt),  32'd1);
    chk("br_idle_adr", 32'(m_addr), 32'd31);
    tick(); idle(); #2;
    chk("br_mem31", 32'(mem[31]), 32'h0BAD);

    // Reset in the middle of a locked read burst.
    tick();
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b0; l_addr = 8'd5;
    #2;
    chk("rr_gnt0", 32'(l_gnt), 32'd1);
    sb.push_back(16'd5);
    tick();
    l_addr = 8'd6; p_rd = 1'b1; p_addr = 8'd9;
    #2;
    chk("rr_gnt1",   32'(l_gnt),    32'd1);
    chk("rr_stall1", 32'(p_stall),  32'd1);
    chk("rr_rv1",    32'(l_rvalid), 32'd1);
    pop_chk("rr_rdata", l_rdata);
    tick();
    rst = 1'b0;
    #2;
    chk("rr_rst_gnt",   32'(l_gnt),        32'd0);
    chk("rr_rst_m_we",  32'(m_we),         32'd0);
    chk("rr_rst_rv",    32'(l_rvalid),     32'd0);
    chk("rr_rst_stall", 32'(p_stall),      32'd0);
    chk("rr_rst_conf",  32'(conflict_cnt), 32'd0);
    tick(); #2;
    chk("rr_rst_rv2", 32'(l_rvalid), 32'd0);
    rst = 1'b1;
    idle();
    p_rd = 1'b1; p_addr = 8'd9; l_req = 1'b1; l_lock = 1'b1; l_addr = 8'd6;
    #1;
    chk("rr_post_stall", 32'(p_stall),      32'd0);
    chk("rr_post_rdata", 32'(p_rdata),      32'd9);
    chk("rr_post_gnt",   32'(l_gnt),        32'd0);
    chk("rr_post_conf",  32'(conflict_cnt), 32'd0);
    tick(); idle(); #2;
    chk("rr_post_rv",    32'(l_rvalid),     32'd0);
    chk("rr_post_conf1", 32'(conflict_cnt), 32'd1);

    // Simultaneous rd+wr is a write.
    tick();
    p_rd = 1'b1; p_wr = 1'b1; p_addr = 8'd0; p_wdata = 16'hABCD;
    #2;
    chk("rw_m_we",    32'(m_we),    32'd1);
    chk("rw_m_wdata", 32'(m_wdata), 32'hABCD);
    chk("rw_p_rdata", 32'(p_rdata), 32'd0);
    chk("rw_p_stall", 32'(p_stall), 32'd0);
    tick(); idle(); #2;
    chk("rw_mem0", 32'(mem[0]), 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port 256x16 data memory between two requesters: the pipeline MEM stage and a loader/debug port.
- The loader preloads and inspects memory in place of hierarchical testbench writes.
- The pipeline has priority by default. A starvation guard and a lockable loader burst mode share the memory fairly.
- Sits between the Datapath MEM stage and the data memory. It stalls the pipeline when the pipeline loses a slot.

Parameters:
DW, 16, data width
AW, 8, address width
MAX_WAIT, 4, consecutive denied loader cycles before a forced loader grant
LOCK_MAX, 8, maximum loader grants per locked burst

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
p_rd  in  1  pipeline read request
p_wr  in  1  pipeline write request
p_addr  in  AW  pipeline address
p_wdata  in  DW  pipeline write data
p_rdata  out  DW  pipeline read data, same cycle
p_stall  out  1  pipeline access denied this cycle
l_req  in  1  loader request
l_we  in  1  loader write enable
l_lock  in  1  loader requests exclusive burst
l_addr  in  AW  loader address
l_wdata  in  DW  loader write data
l_gnt  out  1  loader access performed this cycle
l_rvalid  out  1  loader read data valid, 1 cycle after granted read
l_rdata  out  DW  loader read data, registered
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, combinational from m_addr
conflict_cnt  out  16  cycles with both requesters active, saturating

Behaviour:
- Request and stall definitions:
  - p_req = p_rd | p_wr. If both are set, the access is a write.
  - p_stall = p_req & ~pipeline grant.
- FSM states: IDLE, LOCKED, COOLDOWN. Registered state includes wait_cnt (0..MAX_WAIT) and lock_cnt (0..LOCK_MAX).
- Grant is combinational from registered state plus inputs. At most one grant per cycle.
- IDLE grant order:
  - Forced loader grant if l_req & wait_cnt==MAX_WAIT.
  - Otherwise pipeline if p_req.
  - Otherwise loader if l_req.
- IDLE transition: a loader grant with l_lock=1 goes to LOCKED with lock_cnt=1.
- LOCKED:
  - If l_req & l_lock: loader is granted and the pipeline is stalled. lock_cnt increments.
  - When lock_cnt reaches LOCK_MAX (after that grant), go to COOLDOWN.
  - If l_req=0 or l_lock=0: that cycle arbitrates as IDLE without the forced term, then go to COOLDOWN.
- COOLDOWN:
  - Loader is never granted; pipeline is granted if p_req.
  - lock_cnt clears. Next state is IDLE.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on cycles with l_req & ~l_gnt.
  - Clears on l_gnt or ~l_req.
- Memory drive:
  - Pipeline grant: m_addr=p_addr, m_wdata=p_wdata, m_we=p_wr.
  - Loader grant: m_addr=l_addr, m_wdata=l_wdata, m_we=l_we.
  - No grant: m_we=0, m_addr=0, m_wdata=0.
- p_rdata = m_rdata when the pipeline is granted a read, else 0. Read latency is 0.
- Loader reads: on a granted read (l_we=0), l_rdata<=m_rdata and l_rvalid<=1 at the next edge. l_rvalid is otherwise 0. l_rdata holds its last value.
- conflict_cnt increments on every cycle with p_req & l_req, saturating at 16'hFFFF.
- Reset (rst=0, asynchronous):
  - state=IDLE, wait_cnt=0, lock_cnt=0, l_rvalid=0, l_rdata=0, conflict_cnt=0.
  - While rst=0, all grants are 0: l_gnt=0, p_stall=0, m_we=0, m_addr=0, m_wdata=0, p_rdata=0.
  - Reset mid-burst or with a read in flight discards it; no l_rvalid is issued after release.

Test Plan:
- Reset release, then p_wr=1, p_addr=250, p_wdata=13, loader idle -> same cycle m_we=1, m_addr=250, m_wdata=13, p_stall=0.
- Memory preset mem[i]=i; l_req=1, l_we=0, l_addr=7, pipeline idle -> l_gnt=1 that cycle; next cycle l_rvalid=1, l_rdata=7, then l_rvalid=0.
- p_rd held high and l_req held high (l_addr=3) from cycle 0 -> loader denied cycles 0-3, l_gnt=1 and p_stall=1 only on cycle 4, pipeline granted cycle 5. conflict_cnt=6 after 6 cycles.
- Pipeline idle, loader write with l_lock=1 granted, then p_rd and l_req/l_lock held for 10 cycles -> 8 consecutive loader grants with p_stall=1 from the 2nd cycle onward, then one COOLDOWN cycle with pipeline granted and l_gnt=0.
- rst driven low during LOCKED with a loader read granted the previous cycle -> l_gnt=0, m_we=0, l_rvalid=0 immediately. After release, state is IDLE and a pipeline request is granted at once with conflict_cnt=0.
- p_rd=1 and p_wr=1 together, p_addr=0, p_wdata=16'hABCD -> m_we=1 and mem[0]=16'hABCD next cycle.
